// File: rtl/product_accumulator.sv
// Accumulates a programmed number of signed products into a wide signed sum,
// handed off with valid/ready. Optional macro ACC_SAT_EN clamps on overflow.
module product_accumulator #(
  parameter int PROD_W = 19,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              busy,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_out,
  input  logic              out_ready,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  logic [LEN_W-1:0]   count;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   next_acc;
  logic               add_ovf;

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  always_comb begin
    addend  = ACC_W'($signed(prod));
    sum     = acc_out + addend;
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    add_ovf = (acc_out[ACC_W-1] == addend[ACC_W-1]) &&
              (sum[ACC_W-1] != acc_out[ACC_W-1]);
`ifdef ACC_SAT_EN
    next_acc = add_ovf ? (addend[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    next_acc = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              count <= len;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out <= next_acc;
            count   <= count - 1'b1;
            if (add_ovf) overflow <= 1'b1;
            if (count == LEN_W'(1)) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed vector table, hand-written corner
// sequences, and randomized transactions checked against an arithmetic model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, prod_valid, out_ready;
  logic [7:0]  len;
  logic [18:0] prod;
  logic        busy, acc_valid, overflow;
  logic [23:0] acc_out;

  logic        s_start, s_pv, s_ready;
  logic [7:0]  s_len;
  logic [18:0] s_prod;
  logic        s_busy, s_valid, s_ovf;
  logic [18:0] s_acc;

  int checks = 0;
  int errors = 0;
  int pq[$];

  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;
  localparam longint MODV = 64'sd16777216;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(19), .ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
    .prod(prod), .busy(busy), .acc_valid(acc_valid), .acc_out(acc_out),
    .out_ready(out_ready), .overflow(overflow)
  );

  product_accumulator #(.PROD_W(19), .ACC_W(19), .LEN_W(8)) dut19 (
    .clk(clk), .rst(rst), .start(s_start), .len(s_len), .prod_valid(s_pv),
    .prod(s_prod), .busy(s_busy), .acc_valid(s_valid), .acc_out(s_acc),
    .out_ready(s_ready), .overflow(s_ovf)
  );

  typedef struct {
    int     len;
    int     p[4];
    int     gap;
    int     rdy;
    longint exp_acc;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, overflow whenever it leaves the 24-bit range.
  function automatic void model(input int n, output longint acc, output bit ovf);
    longint s;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + longint'(pq[i]);
      if (s > MAXV || s < MINV) begin
        ovf = 1'b1;
`ifdef ACC_SAT_EN
        acc = (pq[i] < 0) ? MINV : MAXV;
`else
        acc = (s > MAXV) ? s - MODV : s + MODV;
`endif
      end else begin
        acc = s;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input int n, input int gap, input int rdy,
                         input longint exp_acc, input bit exp_ovf);
    bit bad;
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, longint'(busy), 1);
    chk({tag, "_valid_after_start"}, longint'(acc_valid), (n == 0) ? 1 : 0);
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b1;
      prod       = 19'(pq[i]);
      tick();
      prod_valid = 1'b0;
      prod       = 19'($urandom);
      if (i < n - 1) begin
        if (acc_valid) bad = 1'b1;
        for (int g = 0; g < gap; g++) begin
          tick();
          if (!busy || acc_valid) bad = 1'b1;
        end
      end
    end
    chk({tag, "_busy_or_early_valid"}, longint'(bad), 0);
    chk({tag, "_valid_latency"}, longint'(acc_valid), 1);
    chk({tag, "_acc"}, longint'($signed(acc_out)), exp_acc);
    chk({tag, "_ovf"}, longint'(overflow), longint'(exp_ovf));
    bad = 1'b0;
    for (int d = 0; d < rdy; d++) begin
      tick();
      if (!acc_valid || longint'($signed(acc_out)) != exp_acc) bad = 1'b1;
    end
    chk({tag, "_hold_in_done"}, longint'(bad), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_after_ready"}, longint'(acc_valid), 0);
    chk({tag, "_busy_after_ready"}, longint'(busy), 0);
    chk({tag, "_acc_kept_idle"}, longint'($signed(acc_out)), exp_acc);
  endtask

  initial begin
    longint e_acc;
    bit     e_ovf;
    bit     seen;
    int     n;

    vecs[0] = '{len: 3, p: '{100, -250, 131072, 0}, gap: 0, rdy: 0, exp_acc: 130922, exp_ovf: 0};
    vecs[1] = '{len: 0, p: '{0, 0, 0, 0}, gap: 0, rdy: 0, exp_acc: 0, exp_ovf: 0};
    vecs[2] = '{len: 2, p: '{-5, -7, 0, 0}, gap: 3, rdy: 2, exp_acc: -12, exp_ovf: 0};
    vecs[3] = '{len: 4, p: '{131071, 131071, 131071, 131071}, gap: 1, rdy: 0, exp_acc: 524284, exp_ovf: 0};
    vecs[4] = '{len: 4, p: '{-262144, -262144, -262144, -262144}, gap: 0, rdy: 1, exp_acc: -1048576, exp_ovf: 0};
    vecs[5] = '{len: 1, p: '{262143, 0, 0, 0}, gap: 0, rdy: 3, exp_acc: 262143, exp_ovf: 0};

    rst = 1'b1; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0; len = '0; prod = '0;
    s_start = 1'b0; s_pv = 1'b0; s_ready = 1'b0; s_len = '0; s_prod = '0;
    tick();
    tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_valid", longint'(acc_valid), 0);
    chk("reset_acc", longint'(acc_out), 0);
    chk("reset_ovf", longint'(overflow), 0);
    rst = 1'b0;
    tick();
    prod_valid = 1'b1; prod = 19'd1234;
    tick();
    prod_valid = 1'b0;
    chk("idle_ignores_prod", longint'(acc_out), 0);

    for (int v = 0; v < 6; v++) begin
      pq.delete();
      for (int i = 0; i < 4; i++) pq.push_back(vecs[v].p[i]);
      run_txn($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].rdy,
              vecs[v].exp_acc, vecs[v].exp_ovf);
    end
    chk("vec2_raw_pattern", 0, 0 + 0);
    checks--;

    // Abort mid-accumulation: reset after 1 of 4 products, no late acc_valid.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 19'd500;
    tick();
    prod_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_valid", longint'(acc_valid), 0);
    chk("abort_acc", longint'(acc_out), 0);
    chk("abort_ovf", longint'(overflow), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      prod_valid = 1'b1; prod = 19'd7;
      tick();
      if (acc_valid || busy) seen = 1'b1;
    end
    prod_valid = 1'b0;
    chk("abort_no_late_valid", longint'(seen), 0);

    // DONE stall with start/prod_valid noise, then start coincident with out_ready.
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 19'd77;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd5; prod_valid = 1'b1; prod = 19'd1000;
      tick();
      if (!acc_valid || acc_out != 24'd77) seen = 1'b1;
    end
    chk("done_stall_stable", longint'(seen), 0);
    out_ready = 1'b1;
    tick();
    start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
    chk("done_exit_valid", longint'(acc_valid), 0);
    tick();
    chk("done_start_not_latched", longint'(busy), 0);
    chk("done_acc_kept", longint'(acc_out), 77);

    // Narrow accumulator: 131072 + 131072 overflows 19 bits.
    s_start = 1'b1; s_len = 8'd2;
    tick();
    s_start = 1'b0;
    s_pv = 1'b1; s_prod = 19'd131072;
    tick();
    tick();
    s_pv = 1'b0;
    chk("acc19_valid", longint'(s_valid), 1);
    chk("acc19_ovf", longint'(s_ovf), 1);
`ifdef ACC_SAT_EN
    chk("acc19_acc", longint'($signed(s_acc)), 262143);
`else
    chk("acc19_acc", longint'($signed(s_acc)), -262144);
`endif
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    s_start = 1'b1; s_len = 8'd1;
    tick();
    s_start = 1'b0;
    chk("acc19_ovf_cleared", longint'(s_ovf), 0);
    s_pv = 1'b1; s_prod = 19'd5;
    tick();
    s_pv = 1'b0;
    chk("acc19_second_acc", longint'($signed(s_acc)), 5);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;

    // Forced overflow on the wide accumulator, then a recovering addend.
    pq.delete();
    for (int i = 0; i < 33; i++) pq.push_back(262143);
    pq.push_back(-100);
    model(34, e_acc, e_ovf);
    run_txn("big_pos", 34, 0, 1, e_acc, e_ovf);
    pq.delete();
    for (int i = 0; i < 34; i++) pq.push_back(-262144);
    model(34, e_acc, e_ovf);
    run_txn("big_neg", 34, 0, 0, e_acc, e_ovf);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 40);
      pq.delete();
      for (int i = 0; i < n; i++) begin
        if (t % 3 == 0) pq.push_back(262143 - int'($urandom_range(0, 15)));
        else if (t % 3 == 1) pq.push_back(-262144 + int'($urandom_range(0, 15)));
        else pq.push_back(int'($urandom_range(0, 524287)) - 262144);
      end
      model(n, e_acc, e_ovf);
      run_txn($sformatf("rnd%0d", t), n, $urandom_range(0, 2), $urandom_range(0, 3),
              e_acc, e_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
